// File: rtl/exp_cordic_pkg.sv
// Shared constants and FSM encoding for the exp CORDIC arbiter (2.14 fixed point).
package exp_cordic_pkg;

  localparam int NUM_W_DEF = 16;

  localparam logic [15:0] ONE     = 16'h4000;
  localparam logic [15:0] SAT_MAX = 16'h7FFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETURN = 2'd3
  } arb_state_t;

endpackage

// File: rtl/exp_cordic_arbiter_rr_priority_picker.sv
// Round-robin picker: first valid requester at or above ptr, wrapping around.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && req_valid[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/exp_cordic_arbiter.sv
// Round-robin front end sharing one exp CORDIC engine, one operation in flight.
// Optional watchdog with saturated error response: define EXP_ARB_TIMEOUT_EN.
module exp_cordic_arbiter
  import exp_cordic_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int NUM_W          = NUM_W_DEF,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ*NUM_W-1:0] req_z,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_W-1:0]         rsp_w,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [NUM_W-1:0]         eng_z0,
  output logic                     eng_in_valid,
  input  logic                     eng_in_ready,
  input  logic [NUM_W-1:0]         eng_w,
  input  logic                     eng_out_valid,
  output logic                     eng_out_ready,
  output logic                     busy,
`ifdef EXP_ARB_TIMEOUT_EN
  output logic                     rsp_err,
  output logic                     eng_flush,
`endif
  output logic [ID_W-1:0]          grant_id
);

  arb_state_t          state;
  logic [ID_W-1:0]     ptr;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;

  rr_priority_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .gnt       (pick_gnt),
    .idx       (pick_idx),
    .any       (pick_any)
  );

  assign req_ready     = (state == S_IDLE) ? pick_gnt : '0;
  assign busy          = (state != S_IDLE);
  assign eng_in_valid  = (state == S_ISSUE);
  // IDLE also accepts so a stray result after reset is drained
  assign eng_out_ready = (state == S_IDLE) || (state == S_WAIT);
  assign rsp_valid     = (state == S_RETURN) ? (NUM_REQ'(1) << grant_id) : '0;

`ifdef EXP_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          tmo_hit;
  assign tmo_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      grant_id <= '0;
      eng_z0   <= '0;
      rsp_w    <= '0;
`ifdef EXP_ARB_TIMEOUT_EN
      tcnt      <= '0;
      rsp_err   <= 1'b0;
      eng_flush <= 1'b0;
`endif
    end else begin
`ifdef EXP_ARB_TIMEOUT_EN
      eng_flush <= 1'b0;
      tcnt      <= (state == S_ISSUE || state == S_WAIT) ? tcnt + 1'b1 : '0;
`endif
      case (state)
        S_IDLE: if (pick_any) begin
          eng_z0   <= req_z[pick_idx*NUM_W +: NUM_W];
          grant_id <= pick_idx;
          ptr      <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state    <= S_ISSUE;
`ifdef EXP_ARB_TIMEOUT_EN
          rsp_err  <= 1'b0;
          tcnt     <= '0;
`endif
        end
        S_ISSUE: if (eng_in_ready) begin
          state <= S_WAIT;
`ifdef EXP_ARB_TIMEOUT_EN
          tcnt  <= '0;
`endif
        end
        S_WAIT: if (eng_out_valid) begin
          rsp_w <= eng_w;
          state <= S_RETURN;
`ifdef EXP_ARB_TIMEOUT_EN
          rsp_err <= 1'b0;
          tcnt    <= '0;
`endif
        end
        S_RETURN: if (rsp_ready[grant_id]) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
`ifdef EXP_ARB_TIMEOUT_EN
      // a real result arriving on the limit cycle still wins
      if (tmo_hit && ((state == S_ISSUE && !eng_in_ready) ||
                      (state == S_WAIT && !eng_out_valid))) begin
        state     <= S_RETURN;
        rsp_w     <= NUM_W'(SAT_MAX);
        rsp_err   <= 1'b1;
        eng_flush <= 1'b1;
        tcnt      <= '0;
      end
`endif
    end
  end

endmodule
